// File: rtl/otter_tmr_pkg.sv
// Shared definitions for the OTTER IOBUS timer/counter: register offsets,
// CTRL bit positions and FSM state type.
package otter_tmr_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PSC_W  = 8;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_TC   = 4'h4;
    localparam logic [3:0] OFF_CNT  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_AUTO    = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_CLR     = 3;
    localparam int unsigned CTRL_PSC_LSB = 8;
    localparam int unsigned CTRL_PSC_MSB = 15;

    localparam int unsigned STAT_FLAG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/otter_tmr_prescaler.sv
// Clock prescaler: counts 0..psc and flags a tick on the terminal value.
module otter_tmr_prescaler
    import otter_tmr_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] pcount;

    always_ff @(posedge CLK) begin
        if (RST || clr || (pcount == psc)) begin
            pcount <= '0;
        end else begin
            pcount <= PSC_W'(pcount + PSC_W'(1));
        end
    end

    assign tick = (pcount == psc);

endmodule

// File: rtl/otter_timer_counter.sv
// Memory-mapped OTTER IOBUS timer/counter with one-shot/auto-reload and a W1C
// interrupt flag. Define TMR_PRESCALE_EN to build the CTRL[15:8] prescaler.
module otter_timer_counter
    import otter_tmr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1120_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IOBUS_ADDR,
    input  logic [DATA_W-1:0] IOBUS_OUT,
    input  logic              IOBUS_WR,
    output logic              TMR_SEL,
    output logic [DATA_W-1:0] TMR_RDATA,
    output logic              TMR_INTR
);

    tmr_state_t        state, state_nxt;
    logic              ctrl_en, ctrl_auto, ctrl_ie;
    logic              en_nxt, auto_nxt, ie_nxt;
    logic [DATA_W-1:0] tc, tc_nxt;
    logic [DATA_W-1:0] cnt, cnt_nxt;
    logic              flag, flag_nxt;
    logic              intr;

    logic              sel_c;
    logic [3:0]        off_c;
    logic              wr_ctrl_c, wr_tc_c, wr_stat_c;
    logic              tick_c;
    logic [PSC_W-1:0]  psc_rd_c;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_c;

    assign sel_c     = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off_c     = {IOBUS_ADDR[3:2], 2'b00};
    assign wr_ctrl_c = IOBUS_WR && sel_c && (off_c == OFF_CTRL);
    assign wr_tc_c   = IOBUS_WR && sel_c && (off_c == OFF_TC);
    assign wr_stat_c = IOBUS_WR && sel_c && (off_c == OFF_STAT);

`ifdef TMR_PRESCALE_EN
    logic [PSC_W-1:0] ctrl_psc, psc_nxt;
    logic             psc_tick;

    // Prescaler phase restarts on every CTRL write and is held while idle.
    otter_tmr_prescaler u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (wr_ctrl_c || (state == IDLE)),
        .psc  (ctrl_psc),
        .tick (psc_tick)
    );

    assign tick_c   = (state == RUN) && psc_tick;
    assign psc_rd_c = ctrl_psc;
    assign unused_c = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16], IOBUS_OUT[7:4]};
`else
    assign tick_c   = (state == RUN);
    assign psc_rd_c = '0;
    assign unused_c = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:8], IOBUS_OUT[7:4]};
`endif

    // Next-state: software writes first, then terminal-count effects so that
    // a simultaneous flag set beats a W1C and a one-shot stop beats an EN write.
    always_comb begin
        state_nxt = state;
        en_nxt    = ctrl_en;
        auto_nxt  = ctrl_auto;
        ie_nxt    = ctrl_ie;
        tc_nxt    = tc;
        cnt_nxt   = cnt;
        flag_nxt  = flag;
`ifdef TMR_PRESCALE_EN
        psc_nxt   = ctrl_psc;
`endif

        if (wr_ctrl_c) begin
            en_nxt   = IOBUS_OUT[CTRL_EN];
            auto_nxt = IOBUS_OUT[CTRL_AUTO];
            ie_nxt   = IOBUS_OUT[CTRL_IE];
`ifdef TMR_PRESCALE_EN
            psc_nxt  = IOBUS_OUT[CTRL_PSC_MSB:CTRL_PSC_LSB];
`endif
        end
        if (wr_tc_c) begin
            tc_nxt = IOBUS_OUT;
        end
        if (wr_stat_c && IOBUS_OUT[STAT_FLAG]) begin
            flag_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (wr_ctrl_c && IOBUS_OUT[CTRL_EN]) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wr_ctrl_c && !IOBUS_OUT[CTRL_EN]) begin
                    state_nxt = IDLE;
                end
                if (tick_c) begin
                    if (cnt >= tc) begin
                        cnt_nxt  = '0;
                        flag_nxt = 1'b1;
                        if (!ctrl_auto) begin
                            en_nxt    = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = DATA_W'(cnt + DATA_W'(1));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wr_ctrl_c && IOBUS_OUT[CTRL_CLR]) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            tc        <= '0;
            cnt       <= '0;
            flag      <= 1'b0;
            intr      <= 1'b0;
`ifdef TMR_PRESCALE_EN
            ctrl_psc  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            ctrl_en   <= en_nxt;
            ctrl_auto <= auto_nxt;
            ctrl_ie   <= ie_nxt;
            tc        <= tc_nxt;
            cnt       <= cnt_nxt;
            flag      <= flag_nxt;
            intr      <= flag_nxt && ie_nxt;
`ifdef TMR_PRESCALE_EN
            ctrl_psc  <= psc_nxt;
`endif
        end
    end

    // Combinational readback of the addressed register; zero outside the window.
    always_comb begin
        rdata_c = '0;
        if (sel_c) begin
            case (off_c)
                OFF_CTRL: rdata_c = {16'h0000, psc_rd_c, 4'h0, 1'b0, ctrl_ie, ctrl_auto, ctrl_en};
                OFF_TC:   rdata_c = tc;
                OFF_CNT:  rdata_c = cnt;
                OFF_STAT: rdata_c = {31'h0, flag};
                default:  rdata_c = '0;
            endcase
        end
    end

    assign TMR_SEL   = sel_c;
    assign TMR_RDATA = rdata_c;
    assign TMR_INTR  = intr;

endmodule

// File: tb/tb_otter_timer_counter.sv
// Self-checking bench for otter_timer_counter: directed scenarios with
// hand-computed expectations, then randomized traffic against a behavioural model.
module tb_otter_timer_counter;

    localparam logic [31:0] BASE   = 32'h1120_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_TC   = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;
    localparam logic [31:0] A_OUT  = 32'h1100_0000;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic        tmr_sel;
    logic [31:0] tmr_rdata;
    logic        tmr_intr;

    int total = 0;
    int bad   = 0;

    bit          chk_en = 1'b0;
    bit          pin_valid = 1'b0;
    logic [33:0] pin_exp = '0;
    string       pin_name = "";

    // Behavioural model of the programmer-visible state.
    logic [31:0] m_tc = '0, m_cnt = '0;
    logic [7:0]  m_psc = '0;
    bit          m_en = 0, m_auto = 0, m_ie = 0, m_flag = 0;
    int unsigned m_phase = 0;

    always #5 clk = ~clk;

    otter_timer_counter #(.BASE_ADDR(BASE)) dut (
        .CLK        (clk),
        .RST        (rst),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .TMR_SEL    (tmr_sel),
        .TMR_RDATA  (tmr_rdata),
        .TMR_INTR   (tmr_intr)
    );

    function automatic logic [33:0] pv(input bit s, input bit i, input logic [31:0] d);
        return {s, i, d};
    endfunction

    // Expected {TMR_SEL, TMR_INTR, TMR_RDATA} for an address given model state.
    function automatic logic [33:0] model_out(input logic [31:0] a);
        logic [31:0] d;
        bit          in_win;
        in_win = ((a >> 4) == (BASE >> 4));
        d = 32'h0;
        if (in_win) begin
            case (a[3:2])
                2'd0: d = {16'h0, m_psc, 5'h0, 1'(m_ie), 1'(m_auto), 1'(m_en)};
                2'd1: d = m_tc;
                2'd2: d = m_cnt;
                default: d = {31'h0, 1'(m_flag)};
            endcase
        end
        return {in_win, m_flag && m_ie, d};
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit          in_win, wc, wt, ws, tick, term;
        int unsigned psc_eff;
        logic [31:0] n_cnt;
        bit          n_en, n_flag;
        if (r) begin
            m_tc = '0; m_cnt = '0; m_psc = '0;
            m_en = 0; m_auto = 0; m_ie = 0; m_flag = 0; m_phase = 0;
            return;
        end
        in_win  = ((a >> 4) == (BASE >> 4));
        wc      = w && in_win && (a[3:2] == 2'd0);
        wt      = w && in_win && (a[3:2] == 2'd1);
        ws      = w && in_win && (a[3:2] == 2'd3);
        psc_eff = int'(m_psc);
        tick    = m_en && (m_phase == psc_eff);
        term    = tick && (m_cnt >= m_tc);

        n_cnt  = term ? 32'h0 : (tick ? m_cnt + 32'd1 : m_cnt);
        if (wc && d[3]) n_cnt = 32'h0;
        n_flag = term ? 1'b1 : ((ws && d[0]) ? 1'b0 : m_flag);
        n_en   = wc ? d[0] : m_en;
        if (term && !m_auto) n_en = 1'b0;

        m_phase = (wc || !m_en) ? 0 : (m_phase + 1) % (psc_eff + 1);
        m_cnt   = n_cnt;
        m_flag  = n_flag;
        m_en    = n_en;
        if (wc) begin
            m_auto = d[1];
            m_ie   = d[2];
`ifdef TMR_PRESCALE_EN
            m_psc  = d[15:8];
`endif
        end
        if (wt) m_tc = d;
    endtask

    // One bus cycle; optional hand-computed pin checked at the negedge.
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit pin, input logic [33:0] pexp, input string pname);
        rst = r; wr = w; addr = a; wdata = d;
        pin_valid = pin; pin_exp = pexp; pin_name = pname;
        @(negedge clk);
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
        pin_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        step(0, 0, a, 32'h0, 0, '0, "");
    endtask

    task automatic wrt(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, a, d, 0, '0, "");
    endtask

    task automatic rd_pin(input logic [31:0] a, input logic [33:0] e, input string n);
        step(0, 0, a, 32'h0, 1, e, n);
    endtask

    // Sole compare process: model check every cycle, plus any pinned literal.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({tmr_sel, tmr_intr, tmr_rdata} !== model_out(addr)) begin
                bad++;
                $display("FAIL model t=%0t addr=%h: got sel=%b intr=%b rdata=%h want %h",
                         $time, addr, tmr_sel, tmr_intr, tmr_rdata, model_out(addr));
            end
            if (pin_valid) begin
                total++;
                if ({tmr_sel, tmr_intr, tmr_rdata} !== pin_exp) begin
                    bad++;
                    $display("FAIL %s: got {sel,intr,rdata}=%h want %h", pin_name,
                             {tmr_sel, tmr_intr, tmr_rdata}, pin_exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int          kind;

        // Reset
        step(1, 0, A_CTRL, 32'h0, 0, '0, "");
        chk_en = 1'b1;
        rd_pin(A_CTRL, pv(1, 0, 0), "reset_ctrl");
        rd_pin(A_TC,   pv(1, 0, 0), "reset_tc");
        rd_pin(A_CNT,  pv(1, 0, 0), "reset_cnt");
        rd_pin(A_STAT, pv(1, 0, 0), "reset_stat");
        rd_pin(A_OUT,  pv(0, 0, 0), "outside_window");

        // One-shot, TC=5: six ticks then flag, EN auto-cleared, count parked at 0
        wrt(A_TC, 32'd5);
        wrt(A_CTRL, 32'h5);
        for (int k = 0; k < 6; k++) rd_pin(A_CNT, pv(1, 0, 32'(k)), "oneshot_cnt");
        rd_pin(A_STAT, pv(1, 1, 1), "oneshot_flag");
        rd_pin(A_CTRL, pv(1, 1, 32'h4), "oneshot_ctrl");
        rd_pin(A_CNT,  pv(1, 1, 0), "oneshot_cnt_hold0");
        rd_pin(A_CNT,  pv(1, 1, 0), "oneshot_cnt_hold1");
        step(0, 1, A_STAT, 32'h1, 1, pv(1, 1, 1), "w1c_cycle");
        rd_pin(A_STAT, pv(1, 0, 0), "w1c_cleared");

`ifdef TMR_PRESCALE_EN
        // Auto-reload with PSC=3: each count held 4 clocks, event every 12
        wrt(A_TC, 32'd2);
        wrt(A_CTRL, 32'h307);
        for (int i = 0; i < 24; i++)
            rd_pin(A_CNT, pv(1, i >= 12, 32'((i / 4) % 3)), "psc_cnt");
        wrt(A_CTRL, 32'h0);
        wrt(A_STAT, 32'h1);
`endif

        // Lowering TC below CNT fires on the next tick
        wrt(A_TC, 32'd100);
        wrt(A_CTRL, 32'h1);
        for (int i = 0; i < 50; i++) rd_pin(A_CNT, pv(1, 0, 32'(i)), "tclow_run");
        step(0, 1, A_TC, 32'd10, 1, pv(1, 0, 32'd100), "tclow_write");
        rd_pin(A_CNT,  pv(1, 0, 32'd51), "tclow_cnt51");
        rd_pin(A_CNT,  pv(1, 0, 32'd0), "tclow_wrapped");
        rd_pin(A_STAT, pv(1, 0, 32'd1), "tclow_flag");
        rd_pin(A_CTRL, pv(1, 0, 32'd0), "tclow_stopped");
        wrt(A_STAT, 32'h1);

        // Set-vs-clear race: W1C on the terminal edge leaves FLAG set
        wrt(A_TC, 32'd3);
        wrt(A_CTRL, 32'h7);
        for (int i = 0; i < 7; i++) rd_pin(A_CNT, pv(1, i >= 4, 32'(i % 4)), "race_cnt");
        step(0, 1, A_STAT, 32'h1, 1, pv(1, 1, 1), "race_w1c_cycle");
        rd_pin(A_STAT, pv(1, 1, 1), "race_flag_kept");
        wrt(A_STAT, 32'h1);
        rd_pin(A_STAT, pv(1, 0, 0), "race_later_clear");
        wrt(A_CTRL, 32'h0);
        wrt(A_STAT, 32'h1);

        // Mid-run reset at CNT=7 with FLAG=1
        wrt(A_TC, 32'd0);
        wrt(A_CTRL, 32'h5);
        rd(A_CNT);
        wrt(A_TC, 32'd100);
        wrt(A_CTRL, 32'h5);
        for (int i = 0; i < 7; i++) rd_pin(A_CNT, pv(1, 1, 32'(i)), "rst_prerun");
        step(1, 0, A_CNT, 32'h0, 1, pv(1, 1, 32'd7), "rst_cycle");
        rd_pin(A_CTRL, pv(1, 0, 0), "rst_ctrl");
        rd_pin(A_TC,   pv(1, 0, 0), "rst_tc");
        rd_pin(A_STAT, pv(1, 0, 0), "rst_stat");
        for (int i = 0; i < 4; i++) rd_pin(A_CNT, pv(1, 0, 0), "rst_no_count");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 11);
            d    = $urandom;
            a    = BASE + {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 299) == 0) begin
                step(1, 0, a, d, 0, '0, "");
            end else if (kind <= 1) begin
                d[15:8] = 8'($urandom_range(0, 3));
                d[0]    = ($urandom_range(0, 3) != 0);
                d[3]    = ($urandom_range(0, 7) == 0);
                wrt(A_CTRL, d);
            end else if (kind == 2) begin
                wrt(A_TC, 32'($urandom_range(0, 12)));
            end else if (kind == 3) begin
                wrt(A_STAT, d);
            end else if (kind == 4) begin
                wrt(A_CNT, d);
            end else if (kind == 5) begin
                wrt(A_OUT + 32'($urandom_range(0, 15)), d);
            end else if (kind == 6) begin
                rd($urandom);
            end else begin
                rd(a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_timer_counter.md
Name: otter_timer_counter

Overview:
- Memory-mapped timer/counter peripheral on the OTTER IOBUS, directly downstream of the CPU's IOBUS_WR/IOBUS_ADDR/IOBUS_OUT outputs.
- Returns readback data toward the CPU's IOBUS_IN mux.
- Drives the CPU INTR input when a programmed terminal count is reached.
- Supports one-shot and auto-reload modes with a level interrupt that software clears by writing 1 to the flag.

Parameters:
- BASE_ADDR, 32'h1120_0000, word-aligned base of the 16-byte register window.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- IOBUS_ADDR  in  32  CPU IO address.
- IOBUS_OUT  in  32  CPU write data.
- IOBUS_WR  in  1  CPU write strobe, one cycle per store.
- TMR_SEL  out  1  high when IOBUS_ADDR is inside the window; used by the top-level IOBUS_IN mux.
- TMR_RDATA  out  32  readback data; 0 when TMR_SEL=0.
- TMR_INTR  out  1  interrupt request to the CPU INTR input.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Register map (offset from BASE_ADDR, address bits [1:0] ignored):
  - +0x0 CTRL (R/W): [0] EN, [1] AUTO (1 = reload, 0 = one-shot), [2] IE, [3] CLR (write-only, reads 0), [15:8] PSC.
  - +0x4 TC (R/W): terminal count.
  - +0x8 CNT (RO): current count; writes ignored.
  - +0xC STAT (R/W1C): [0] FLAG.
  - Other addresses inside the window read 0; writes to them are ignored.
- Reset values: CTRL=0, TC=0, CNT=0, prescaler=0, FLAG=0, FSM=IDLE, TMR_INTR=0.
- Write latency: a register is updated on the CLK edge at which IOBUS_WR=1 and the address decodes. Readback is combinational from current register state.
- FSM, two states:
  - IDLE: CNT holds its value. Goes to RUN on the edge where EN becomes 1.
  - RUN: CNT advances by 1 on each tick. Goes to IDLE when EN=0 (software clear, or automatic clear in one-shot).
- Tick: the prescaler counts 0..PSC and produces a tick when it equals PSC, i.e. one tick every PSC+1 clocks. The prescaler resets to 0 on any CTRL write and whenever the FSM is in IDLE.
- Terminal event, on a tick in RUN with CNT >= TC:
  - CNT <= 0 and FLAG <= 1.
  - If AUTO=0, EN <= 0 and the FSM goes to IDLE.
  - Using >= means that lowering TC below CNT fires on the next tick and never runs through 2^32.
- TC=0: a terminal event occurs on every tick.
- CLR=1 written: CNT <= 0 and prescaler <= 0 in that cycle; the other CTRL bits take the written values.
- TMR_INTR = FLAG & IE. This is a level signal held until FLAG is cleared. Clearing IE masks it without clearing FLAG.
- Simultaneous events:
  - W1C of FLAG on the same edge as a terminal event: FLAG stays 1 (set wins).
  - CTRL write with EN=0 on the same edge as a terminal event: FLAG is set, CNT <= 0, EN=0.
- RST asserted mid-count: every register returns to its reset value on that edge, and the pending interrupt is dropped.

Optional Feature:
- Macro TMR_PRESCALE_EN.
  - Defined: the PSC field and the prescaler exist as described above.
  - Undefined: CTRL[15:8] reads 0 and writes to it are ignored; a tick occurs on every CLK cycle in RUN; no prescaler flops are synthesised.

Decomposition:
- Package otter_tmr_pkg:
  - register offset localparams (OFF_CTRL, OFF_TC, OFF_CNT, OFF_STAT);
  - CTRL bit-index localparams;
  - state enum typedef tmr_state_t {IDLE, RUN}.
- One sub-module, otter_tmr_prescaler: inputs CLK, RST, clr, psc[7:0]; output tick. It is instantiated only under TMR_PRESCALE_EN.

Test Plan:
- Reset: after RST high for 1 cycle, read CTRL/TC/CNT/STAT -> 0,0,0,0 and TMR_INTR=0; an address outside the window gives TMR_SEL=0 and TMR_RDATA=0.
- One-shot: TC=5, CTRL=0x5 (EN, IE) -> FLAG set and TMR_INTR high 6 ticks after EN; CTRL reads 0x4; CNT=0 and holds; write STAT=1 -> TMR_INTR low next cycle.
- Auto-reload with prescale (TMR_PRESCALE_EN): TC=2, PSC=3, CTRL=0x307 -> terminal events every 12 clocks; CNT sequence 0,1,2,0 with each value held 4 clocks.
- TC lowered below CNT: running with TC=100, at CNT=50 write TC=10 -> terminal event on the next tick, then CNT=0.
- Set-vs-clear race: W1C to STAT on the same edge as a terminal event -> FLAG stays 1 and TMR_INTR stays high.
- Mid-run reset: RST during RUN at CNT=7 with FLAG=1 -> next cycle all registers 0, TMR_INTR=0, FSM=IDLE, and no further counting.
